// File: rtl/ciphertext_packer_pkg.sv
// Shared constants and types for the ciphertext output framer.
`timescale 1ns/1ps
package ciphertext_packer_pkg;

   localparam logic [3:0] HDR_MAGIC = 4'hC;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HEADER = 2'd1,
      ST_DATA   = 2'd2
   } state_t;

   function automatic int nchunk(input int dw, input int ow);
      return (dw + ow - 1) / ow;
   endfunction

endpackage

// File: rtl/ciphertext_packer.sv
// Captures one ElGamal ciphertext and streams it as a header beat followed by
// OUTWIDTH-bit coordinate chunks, MSB chunk first, optionally point-compressed.
`timescale 1ns/1ps
module ciphertext_packer
   import ciphertext_packer_pkg::*;
#(
   parameter int DATAWIDTH = 16,
   parameter int OUTWIDTH  = 8,
   parameter int COMPRESS  = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATAWIDTH-1:0] C1x_in,
   input  logic [DATAWIDTH-1:0] C1y_in,
   input  logic [DATAWIDTH-1:0] C2x_in,
   input  logic [DATAWIDTH-1:0] C2y_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUTWIDTH-1:0]  out_data,
   output logic                 out_last
);

   localparam int NCHUNK = nchunk(DATAWIDTH, OUTWIDTH);
   localparam int PADW   = NCHUNK * OUTWIDTH;
   localparam int CHW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int NCOORD = (COMPRESS != 0) ? 2 : 4;
   localparam int CRW    = $clog2(NCOORD);
   localparam logic [CHW-1:0] CHUNK_LAST = CHW'(NCHUNK - 1);
   localparam logic [CRW-1:0] COORD_LAST = CRW'(NCOORD - 1);

   state_t                state_q, state_d;
   logic [CRW-1:0]        coord_q, coord_d;
   logic [CHW-1:0]        chunk_q, chunk_d;
   logic [DATAWIDTH-1:0]  c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic [OUTWIDTH-1:0]   out_data_q, out_data_d;
   logic                  out_last_q, out_last_d;

   function automatic logic [OUTWIDTH-1:0] header(input logic c1y_par, input logic c2y_par);
      logic [OUTWIDTH-1:0] h;
      h      = '0;
      h[7:4] = HDR_MAGIC;
      h[3]   = (COMPRESS != 0);
      h[1]   = (COMPRESS != 0) && c1y_par;
      h[0]   = (COMPRESS != 0) && c2y_par;
      return h;
   endfunction

   // Compressed frames walk only the x coordinates: index 0 -> C1x, 1 -> C2x.
   function automatic logic [DATAWIDTH-1:0] coord_mux(input logic [CRW-1:0] idx);
      logic [1:0] sel;
      sel = (COMPRESS != 0) ? {idx[0], 1'b0} : 2'(idx);
      case (sel)
         2'd0:    return c1x_q;
         2'd1:    return c1y_q;
         2'd2:    return c2x_q;
         default: return c2y_q;
      endcase
   endfunction

   function automatic logic [OUTWIDTH-1:0] chunk_sel(input logic [DATAWIDTH-1:0] coord,
                                                     input logic [CHW-1:0] idx);
      logic [PADW-1:0] padded;
      padded = PADW'(coord);
      return padded[(NCHUNK - 1 - int'(idx)) * OUTWIDTH +: OUTWIDTH];
   endfunction

   always_comb begin
      state_d     = state_q;
      coord_d     = coord_q;
      chunk_d     = chunk_q;
      c1x_d       = c1x_q;
      c1y_d       = c1y_q;
      c2x_d       = c2x_q;
      c2y_d       = c2y_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               c1x_d       = C1x_in;
               c1y_d       = C1y_in;
               c2x_d       = C2x_in;
               c2y_d       = C2y_in;
               state_d     = ST_HEADER;
               out_valid_d = 1'b1;
               out_data_d  = header(C1y_in[0], C2y_in[0]);
               out_last_d  = 1'b0;
            end
         end
         ST_HEADER: begin
            if (out_ready) begin
               state_d    = ST_DATA;
               coord_d    = '0;
               chunk_d    = '0;
               out_data_d = chunk_sel(coord_mux('0), '0);
               out_last_d = 1'b0;
            end
         end
         ST_DATA: begin
            if (out_ready) begin
               if (out_last_q) begin
                  state_d     = ST_IDLE;
                  coord_d     = '0;
                  chunk_d     = '0;
                  out_valid_d = 1'b0;
                  out_data_d  = '0;
                  out_last_d  = 1'b0;
               end else begin
                  if (chunk_q == CHUNK_LAST) begin
                     chunk_d = '0;
                     coord_d = coord_q + 1'b1;
                  end else begin
                     chunk_d = chunk_q + 1'b1;
                  end
                  // Next beat is preloaded so outputs stay purely registered.
                  out_data_d = chunk_sel(coord_mux(coord_d), chunk_d);
                  out_last_d = (coord_d == COORD_LAST) && (chunk_d == CHUNK_LAST);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      in_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         coord_q     <= '0;
         chunk_q     <= '0;
         c1x_q       <= '0;
         c1y_q       <= '0;
         c2x_q       <= '0;
         c2y_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         coord_q     <= coord_d;
         chunk_q     <= chunk_d;
         c1x_q       <= c1x_d;
         c1y_q       <= c1y_d;
         c2x_q       <= c2x_d;
         c2y_q       <= c2y_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_ciphertext_packer.sv
// Scoreboard bench: three packer configurations (16b plain, 16b compressed, 12b plain) share stimulus.
`timescale 1ns/1ps
module tb_ciphertext_packer;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] c1x, c1y, c2x, c2y;
   logic        ir [3];
   logic        ov [3];
   logic        ol [3];
   logic [7:0]  od [3];

   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   logic bp_mode = 1'b0;

   int   dw_a   [3] = '{16, 16, 12};
   int   comp_a [3] = '{0, 1, 0};
   exp_t exp_q  [3][$];
   logic hold   [3];
   logic [7:0] held_d [3];
   logic held_l [3];
   int   nbeats   [3];
   int   acc_cyc  [3];
   int   last_cyc [3];

   ciphertext_packer #(.DATAWIDTH(16), .OUTWIDTH(8), .COMPRESS(0)) u_plain16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
      .C1x_in(c1x), .C1y_in(c1y), .C2x_in(c2x), .C2y_in(c2y),
      .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_last(ol[0]));

   ciphertext_packer #(.DATAWIDTH(16), .OUTWIDTH(8), .COMPRESS(1)) u_comp16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
      .C1x_in(c1x), .C1y_in(c1y), .C2x_in(c2x), .C2y_in(c2y),
      .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_last(ol[1]));

   ciphertext_packer #(.DATAWIDTH(12), .OUTWIDTH(8), .COMPRESS(0)) u_plain12 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
      .C1x_in(c1x[11:0]), .C1y_in(c1y[11:0]), .C2x_in(c2x[11:0]), .C2y_in(c2y[11:0]),
      .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_last(ol[2]));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      out_ready = bp_mode ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_frame(input int i, input logic [15:0] a, b, c, d);
      int          dw;
      int          n;
      int          nc;
      logic [31:0] m;
      logic [31:0] cl [4];
      exp_t        e;
      dw    = dw_a[i];
      n     = (dw + 7) / 8;
      m     = (32'h1 << dw) - 32'h1;
      cl[0] = {16'h0, a} & m;
      cl[1] = {16'h0, b} & m;
      cl[2] = {16'h0, c} & m;
      cl[3] = {16'h0, d} & m;
      e.d   = 8'hC0;
      e.l   = 1'b0;
      if (comp_a[i] != 0) begin
         cl[1] = cl[2];
         nc    = 2;
         e.d   = e.d | 8'h08 | {6'b0, b[0], d[0]};
      end else begin
         nc = 4;
      end
      exp_q[i].push_back(e);
      for (int j = 0; j < nc; j++) begin
         for (int k = 0; k < n; k++) begin
            e.d = 8'((cl[j] >> ((n - 1 - k) * 8)) & 32'hFF);
            e.l = (j == nc - 1) && (k == n - 1);
            exp_q[i].push_back(e);
         end
      end
   endtask

   task automatic mon_step(input int i);
      exp_t e;
      if (hold[i]) begin
         chk($sformatf("stall_valid%0d", i), 32'(ov[i]), 32'd1);
         chk($sformatf("stall_data%0d", i), 32'(od[i]), 32'(held_d[i]));
         chk($sformatf("stall_last%0d", i), 32'(ol[i]), 32'(held_l[i]));
      end
      if (ov[i] && out_ready) begin
         chk($sformatf("beat_expected%0d", i), 32'(exp_q[i].size() != 0), 32'd1);
         if (exp_q[i].size() != 0) begin
            e = exp_q[i].pop_front();
            chk($sformatf("beat_data%0d", i), 32'(od[i]), 32'(e.d));
            chk($sformatf("beat_last%0d", i), 32'(ol[i]), 32'(e.l));
         end
         nbeats[i]++;
         if (ol[i]) last_cyc[i] = cyc;
      end
      if (i == 0 && ov[i]) chk("busy_in_ready0", 32'(ir[0]), 32'd0);
      hold[i]   = ov[i] && !out_ready;
      held_d[i] = od[i];
      held_l[i] = ol[i];
      if (in_valid && ir[i]) begin
         push_frame(i, c1x, c1y, c2x, c2y);
         acc_cyc[i] = cyc;
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst_n) mon_step(i);
         else hold[i] = 1'b0;
      end
   end

   task automatic wait_accept();
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (ir[0]) break;
      end
      chk("accept_seen", 32'(ir[0]), 32'd1);
   endtask

   task automatic send(input logic [15:0] a, b, c, d);
      c1x = a; c1y = b; c2x = c; c2y = d;
      in_valid = 1'b1;
      wait_accept();
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int pending;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         pending = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
         if (ir[0] && ir[1] && ir[2] && pending == 0) break;
      end
      @(posedge clk); #1;
      chk("drain_pending", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'd0);
      chk("drain_idle", 32'({ir[0], ir[1], ir[2]}), 32'h7);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      for (int i = 0; i < 3; i++) begin
         hold[i] = 1'b0; nbeats[i] = 0; acc_cyc[i] = 0; last_cyc[i] = 0;
      end
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      c1x = '0; c1y = '0; c2x = '0; c2y = '0;

      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_out_valid%0d", i), 32'(ov[i]), 32'd0);
         chk($sformatf("rst_out_data%0d", i), 32'(od[i]), 32'd0);
         chk($sformatf("rst_out_last%0d", i), 32'(ol[i]), 32'd0);
         chk($sformatf("rst_in_ready%0d", i), 32'(ir[i]), 32'd0);
      end
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", 32'(ir[0]), 32'd1);

      // Basic frame, full throughput.
      send(16'h1234, 16'h5679, 16'h9ABC, 16'hDEF0);
      wait_idle();
      chk("frame_len_cycles", 32'(last_cyc[0] - acc_cyc[0]), 32'd9);
      chk("frame_len_comp", 32'(last_cyc[1] - acc_cyc[1]), 32'd5);

      // Same frame under back-pressure.
      bp_mode = 1'b1;
      send(16'h1234, 16'h5679, 16'h9ABC, 16'hDEF0);
      wait_idle();
      bp_mode = 1'b0;

      // in_valid held with changing data: second ciphertext taken only after IDLE.
      c1x = 16'hA5A5; c1y = 16'h0F0E; c2x = 16'h3C3C; c2y = 16'h7777;
      in_valid = 1'b1;
      wait_accept();
      @(posedge clk); #1;
      c1x = 16'h1111; c1y = 16'h2223; c2x = 16'h4444; c2y = 16'h8889;
      wait_accept();
      @(posedge clk); #1;
      chk("bubble_cycles", 32'(acc_cyc[0] - last_cyc[0]), 32'd1);
      in_valid = 1'b0;
      wait_idle();

      // 12-bit coordinates are zero padded to two chunks.
      send(16'h0ABC, 16'h0DEF, 16'h0123, 16'h0456);
      wait_idle();

      // Reset in the middle of a frame.
      base = nbeats[0];
      send(16'h0ABC, 16'h0123, 16'h0FED, 16'h0456);
      for (int t = 0; t < 60; t++) begin
         if (nbeats[0] >= base + 4) break;
         @(posedge clk);
      end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("midrst_out_valid%0d", i), 32'(ov[i]), 32'd0);
         chk($sformatf("midrst_in_ready%0d", i), 32'(ir[i]), 32'd0);
         exp_q[i].delete();
      end
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_recover_in_ready", 32'(ir[0]), 32'd1);
      chk("midrst_no_beat", 32'(ov[0]), 32'd0);
      send(16'hCAFE, 16'hBEEF, 16'h0101, 16'h8002);
      wait_idle();

      for (int i = 0; i < 3; i++)
         chk($sformatf("final_queue%0d", i), 32'(exp_q[i].size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
